// File: rtl/park_slot_allocator.sv
// Parking slot allocator: one pending reservation at a time, confirmed by car_in, released by exit_req.
// Optional reservation timeout is built when macro PARK_TIMEOUT_EN is defined.
module park_slot_allocator #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 entry_req,
    input  logic                 car_in,
    input  logic                 exit_req,
    input  logic [IDX_W-1:0]     exit_slot,
    output logic                 grant,
    output logic [IDX_W-1:0]     grant_slot,
    output logic                 reject,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [IDX_W:0]       free_count,
    output logic                 full
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RESERVED = 1'b1;

    if (NUM_SLOTS < 2 || NUM_SLOTS > 64 || TIMEOUT < 1 || TIMEOUT > 255 ||
        (64'd1 << IDX_W) < 64'(NUM_SLOTS)) begin : g_bad_params
        $error("park_slot_allocator: parameter out of range");
    end

    logic [0:0]           state;
    logic [0:0]           state_d;
    logic [NUM_SLOTS-1:0] occ_d;
    logic [NUM_SLOTS-1:0] exit_mask;
    logic [NUM_SLOTS-1:0] res_mask;
    logic [NUM_SLOTS-1:0] car_set;
    logic [IDX_W-1:0]     slot_d;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W:0]       used;
    logic [IDX_W:0]       free_d;
    logic                 have_free;
    logic                 exit_hit;
    logic                 reject_d;
    logic                 exit_err_d;

`ifdef PARK_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_d;
`endif

    // Slot decode: exit target, reserved slot, lowest-index free slot (pre-exit view)
    always_comb begin
        exit_mask = '0;
        res_mask  = '0;
        exit_hit  = 1'b0;
        have_free = 1'b0;
        pick      = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            exit_mask[i] = (exit_slot == IDX_W'(i));
            res_mask[i]  = (grant_slot == IDX_W'(i));
            if (exit_mask[i] && occupancy[i]) begin
                exit_hit = 1'b1;
            end
            if (!have_free && !occupancy[i]) begin
                have_free = 1'b1;
                pick      = IDX_W'(i);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state;
        slot_d     = grant_slot;
        car_set    = '0;
        reject_d   = 1'b0;
        exit_err_d = exit_req && !exit_hit;
`ifdef PARK_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (entry_req) begin
                    if (enable && !full && have_free) begin
                        state_d = RESERVED;
                        slot_d  = pick;
`ifdef PARK_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            RESERVED: begin
                reject_d = entry_req;
                if (car_in) begin
                    car_set = res_mask;
                    state_d = IDLE;
                    slot_d  = '0;
                end
`ifdef PARK_TIMEOUT_EN
                else if (tmo_cnt == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    slot_d  = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase

        // Exit only ever clears a confirmed slot, never the one being reserved
        occ_d = (occupancy | car_set) & ~((exit_req && exit_hit) ? exit_mask : '0);

        used = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            used = used + (IDX_W+1)'(occ_d[i]);
        end
        free_d = (IDX_W+1)'(NUM_SLOTS) - used - (IDX_W+1)'(state_d == RESERVED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            grant_slot <= '0;
            reject     <= 1'b0;
            exit_err   <= 1'b0;
            occupancy  <= '0;
            free_count <= (IDX_W+1)'(NUM_SLOTS);
            full       <= 1'b0;
        end else begin
            state      <= state_d;
            grant      <= (state_d == RESERVED);
            grant_slot <= slot_d;
            reject     <= reject_d;
            exit_err   <= exit_err_d;
            occupancy  <= occ_d;
            free_count <= free_d;
            full       <= (free_d == '0);
        end
    end

`ifdef PARK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_park_slot_allocator.sv
// Scoreboard bench for park_slot_allocator: driver pushes predicted post-edge outputs, monitor pops and compares.
// Honours PARK_TIMEOUT_EN the same way the design does.
module tb_park_slot_allocator;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TO = 16;

    typedef struct packed {
        logic          grant;
        logic [IW-1:0] slot;
        logic          reject;
        logic          exit_err;
        logic [N-1:0]  occ;
        logic [IW:0]   free;
        logic          full;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          entry_req = 1'b0;
    logic          car_in = 1'b0;
    logic          exit_req = 1'b0;
    logic [IW-1:0] exit_slot = '0;
    logic          grant;
    logic [IW-1:0] grant_slot;
    logic          reject;
    logic          exit_err;
    logic [N-1:0]  occupancy;
    logic [IW:0]   free_count;
    logic          full;

    park_slot_allocator #(.NUM_SLOTS(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .entry_req(entry_req),
        .car_in(car_in), .exit_req(exit_req), .exit_slot(exit_slot),
        .grant(grant), .grant_slot(grant_slot), .reject(reject), .exit_err(exit_err),
        .occupancy(occupancy), .free_count(free_count), .full(full)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t exp_q[$];

    // Reference model: which slots hold a car, and the single pending reservation
    bit occ_m[N];
    bit res_m;
    int res_slot_m;
    int age_m;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int count_occ();
        int c = 0;
        for (int i = 0; i < N; i++) c += occ_m[i];
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) occ_m[i] = 1'b0;
        res_m = 1'b0;
        res_slot_m = 0;
        age_m = 0;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge
    task automatic step(input bit en, input bit entry, input bit car, input bit exr, input int exs);
        snap_t e;
        bit    ex_ok;
        int    nfree;
        @(negedge clk);
        enable = en; entry_req = entry; car_in = car; exit_req = exr; exit_slot = IW'(exs);
        e = '0;
        ex_ok = exr && exs < N && occ_m[exs];
        e.exit_err = exr && !ex_ok;
        nfree = N - count_occ() - (res_m ? 1 : 0);
        if (res_m) begin
            e.reject = entry;
            if (car) begin
                occ_m[res_slot_m] = 1'b1;
                res_m = 1'b0;
            end else begin
                age_m++;
`ifdef PARK_TIMEOUT_EN
                if (age_m >= TO) res_m = 1'b0;
`endif
            end
        end else if (entry) begin
            if (en && nfree > 0) begin
                for (int i = N - 1; i >= 0; i--) if (!occ_m[i]) res_slot_m = i;
                res_m = 1'b1;
                age_m = 0;
            end else begin
                e.reject = 1'b1;
            end
        end
        if (ex_ok) occ_m[exs] = 1'b0;
        e.grant = res_m;
        e.slot  = IW'(res_slot_m);
        for (int i = 0; i < N; i++) e.occ[i] = occ_m[i];
        e.free = (IW+1)'(N - count_occ() - (res_m ? 1 : 0));
        e.full = (e.free == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0; entry_req = 1'b0; car_in = 1'b0; exit_req = 1'b0; exit_slot = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_grant_slot", 32'(grant_slot), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_exit_err", 32'(exit_err), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_free_count", 32'(free_count), 32'(N));
        chk("rst_full", 32'(full), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every registered output is compared after each edge that has a prediction
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(grant), 32'(e.grant));
                if (e.grant) chk("grant_slot", 32'(grant_slot), 32'(e.slot));
                chk("reject", 32'(reject), 32'(e.reject));
                chk("exit_err", 32'(exit_err), 32'(e.exit_err));
                chk("occupancy", 32'(occupancy), 32'(e.occ));
                chk("free_count", 32'(free_count), 32'(e.free));
                chk("full", 32'(full), 32'(e.full));
            end
        end
    end

    initial begin
        int wait_cyc;
        model_reset();
        do_reset();
        idle(1);

        // Three entries, each confirmed: slots 0,1,2
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        end
        // Exit slot 1 with simultaneous entry: slot 3 granted, slot 1 freed
        step(1'b1, 1'b1, 1'b0, 1'b1, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Exit of a free slot
        step(1'b1, 1'b0, 1'b0, 1'b1, 5);
        // car_in in IDLE ignored, entry with enable low rejected
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Fill every slot, then entry while full
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(1);
        // Free slot 2, reserve it, then hold without car_in for a long time
        step(1'b1, 1'b0, 1'b0, 1'b1, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(100);
        // Reserve, then car_in plus exit of the reserved slot
        if (!res_m) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, res_slot_m);
        // Reserve again and reset while grant is high
        step(1'b1, 1'b0, 1'b0, 1'b1, 4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        do_reset();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4,
                     $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                     int'($urandom_range(0, N - 1)));
            end
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/park_slot_allocator.md
PARK_SLOT_ALLOCATOR -- requirements
Module: park_slot_allocator

Interface
REQ-001 Parameter NUM_SLOTS, default 8, SHALL set the number of parking slots (2..64).
REQ-002 Parameter IDX_W, default 3, SHALL set the slot-index width (ceil(log2(NUM_SLOTS))).
REQ-003 Parameter TIMEOUT, default 16, SHALL set the reservation timeout in clock cycles (1..255).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  SHALL gate new allocations only when low.
REQ-007 entry_req  in  1  single-cycle pulse requesting a slot.
REQ-008 car_in  in  1  SHALL confirm that the granted car has parked.
REQ-009 exit_req  in  1  single-cycle pulse releasing the slot given on exit_slot.
REQ-010 exit_slot  in  IDX_W  index of the slot being released.
REQ-011 grant  out  1  SHALL be high while a reservation is pending.
REQ-012 grant_slot  out  IDX_W  reserved slot index; valid only while grant is high.
REQ-013 reject  out  1  one-cycle pulse for a refused entry_req.
REQ-014 exit_err  out  1  one-cycle pulse for an illegal exit_req.
REQ-015 occupancy  out  NUM_SLOTS  bit i high = slot i occupied (confirmed).
REQ-016 free_count  out  IDX_W+1  number of slots neither occupied nor reserved.
REQ-017 full  out  1  SHALL be high exactly when free_count == 0.

Function
REQ-018 The FSM SHALL have two states, IDLE and RESERVED.
REQ-019 In IDLE, an entry_req with enable=1 and free_count>0 SHALL reserve the lowest-index free slot and enter RESERVED; grant and grant_slot SHALL be valid on the next cycle (latency 1).
REQ-020 In IDLE, an entry_req with enable=0 or full=1 SHALL pulse reject on the next cycle and leave the state unchanged.
REQ-021 In RESERVED, car_in=1 SHALL set occupancy[grant_slot], clear the reservation, drop grant on the next cycle and return to IDLE.
REQ-022 In RESERVED, an entry_req SHALL be refused with a reject pulse; only one reservation SHALL exist at a time.
REQ-023 car_in in IDLE SHALL be ignored.
REQ-024 A valid exit_req (exit_slot < NUM_SLOTS and occupied) SHALL clear that occupancy bit on the next edge, in any state and regardless of enable.
REQ-025 An exit_req for an out-of-range, free or reserved-only slot SHALL pulse exit_err on the next cycle and change nothing.
REQ-026 When exit_req and entry_req arrive together, the exit SHALL be applied first; a slot freed in that cycle SHALL NOT be allocated before the following cycle.
REQ-027 Simultaneous car_in and exit_req on the same slot SHALL be treated as an illegal exit (exit_err); the car_in SHALL still complete.
REQ-028 free_count and full SHALL be registered and SHALL reflect the state after each edge; free_count SHALL never underflow or exceed NUM_SLOTS.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, occupancy=0, no reservation, grant=0, grant_slot=0, reject=0, exit_err=0, free_count=NUM_SLOTS and full=0.
REQ-030 Reset asserted during RESERVED SHALL discard the reservation; no state SHALL survive reset.

Configuration
REQ-031 With macro PARK_TIMEOUT_EN defined, the block SHALL count cycles spent in RESERVED and, TIMEOUT cycles after grant rises with no car_in, SHALL release the reservation, drop grant and return to IDLE.
REQ-032 With PARK_TIMEOUT_EN undefined, no timeout counter SHALL exist, and RESERVED SHALL persist until car_in or reset.

Verification (NUM_SLOTS=8, TIMEOUT=16)
REQ-033 Reset, then entry_req plus car_in three times -> grant_slot 0,1,2; occupancy=8'h07; free_count=5.
REQ-034 occupancy=8'hFF, entry_req -> reject pulse 1 cycle later; grant stays 0; full=1.
REQ-035 occupancy=8'h07, exit_req slot 1 together with entry_req -> slot 3 granted; occupancy=8'h05 after the edge.
REQ-036 exit_req slot 5 while free -> exit_err pulse; occupancy unchanged.
REQ-037 PARK_TIMEOUT_EN defined, grant slot 0, no car_in for 16 cycles -> grant falls; free_count returns to 8. Undefined -> grant still high after 100 cycles.
REQ-038 rst_n pulsed low while grant=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
